// File: rtl/mips_ctrl_fsm_if.sv
// Signal bundle between the MiniMIPS control FSM and the datapath (Reg_TOP, PC, memory, ALU).
// No valid/ready handshake: op_in/fn_in/zero_in are sampled combinationally every cycle (op/fn
// matter only in DECODE, zero_in only in BRANCH); every output is valid for the whole cycle.
interface mips_ctrl_fsm_if;
  logic [5:0]  op_in;
  logic [5:0]  fn_in;
  logic        zero_in;
  logic [21:0] ctrl_out;
  logic [3:0]  state_out;
  logic        illegal_instr;
  logic        halted;
  logic [31:0] instr_count;

  modport master (
    input  op_in, fn_in, zero_in,
    output ctrl_out, state_out, illegal_instr, halted, instr_count
  );

  modport slave (
    output op_in, fn_in, zero_in,
    input  ctrl_out, state_out, illegal_instr, halted, instr_count
  );
endinterface

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MiniMIPS control unit: Moore FSM producing the 22-bit control word for Reg_TOP.
// Optional fetched-instruction counter enabled by defining MIPS_CTRL_PERF_CNT_EN.
module mips_ctrl_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic            clk,
  input  logic            reset,
  mips_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTYPE  = 4'd6,  S_RWB    = 4'd7,
    S_IMM    = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  typedef struct packed {
    logic       jump_addr;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       inst_data;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] reg_in_src;
    logic       reg_write;
    logic       alu_src_x;
    logic [1:0] alu_src_y;
    logic       add_sub;
    logic [1:0] logic_fn;
    logic [1:0] fn_class;
    logic       br_cond;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'd0,  OP_J    = 6'd2,  OP_JAL  = 6'd3,  OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5,  OP_ADDI = 6'd8,  OP_SLTI = 6'd10, OP_ANDI = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13, OP_XORI = 6'd14, OP_LUI  = 6'd15, OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43, FN_JR   = 6'd8,  FN_SYSCALL = 6'd12;

  // {AddSub, LogicFn, FnClass}; R-type passes fn, immediate forms pass op (codes never overlap in use).
  function automatic logic [4:0] alu_ctrl(input logic [5:0] code);
    case (code)
      6'd32, 6'd8:  alu_ctrl = 5'b0_00_10;
      6'd34:        alu_ctrl = 5'b1_00_10;
      6'd42, 6'd10: alu_ctrl = 5'b1_00_01;
      6'd36, 6'd12: alu_ctrl = 5'b0_00_11;
      6'd37, 6'd13: alu_ctrl = 5'b0_01_11;
      6'd38, 6'd14: alu_ctrl = 5'b0_10_11;
      6'd39:        alu_ctrl = 5'b0_11_11;
      6'd15:        alu_ctrl = 5'b0_00_00;
      default:      alu_ctrl = 5'b0_00_10;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [5:0] op_q, fn_q;
  ctrl_t      ctrl;
  logic       illegal, in_halt, fn_is_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= state_t'(RESET_STATE);
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= bus.op_in;
        fn_q <= bus.fn_in;
      end
    end
  end

  assign fn_is_alu = (bus.fn_in inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42});

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    illegal = 1'b0;
    in_halt = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = 1'b1;
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = 2'b11;
        ctrl.fn_class = 2'b10;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_y = 2'b11;
        ctrl.fn_class  = 2'b10;
        case (bus.op_in)
          OP_RTYPE: begin
            if (fn_is_alu)                     state_d = S_RTYPE;
            else if (bus.fn_in == FN_JR)       state_d = S_JUMP;
            else if (bus.fn_in == FN_SYSCALL)  state_d = S_HALT;
            else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          OP_LW, OP_SW:                                       state_d = S_MEMADR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_IMM;
          OP_BEQ, OP_BNE:                                     state_d = S_BRANCH;
          OP_J, OP_JAL:                                       state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_x = 1'b1;
        ctrl.alu_src_y = 2'b10;
        ctrl.fn_class  = 2'b10;
        state_d        = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.inst_data = 1'b1;
        ctrl.mem_read  = 1'b1;
        state_d        = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.inst_data = 1'b1;
        ctrl.mem_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_RTYPE: begin
        ctrl.alu_src_x = 1'b1;
        ctrl.alu_src_y = 2'b01;
        {ctrl.add_sub, ctrl.logic_fn, ctrl.fn_class} = alu_ctrl(fn_q);
        state_d        = S_RWB;
      end
      S_RWB: begin
        ctrl.reg_dst    = 2'b01;
        ctrl.reg_in_src = 2'b01;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_IMM: begin
        ctrl.alu_src_x = 1'b1;
        ctrl.alu_src_y = 2'b10;
        {ctrl.add_sub, ctrl.logic_fn, ctrl.fn_class} = alu_ctrl(op_q);
        state_d        = S_IWB;
      end
      S_IWB: begin
        ctrl.reg_in_src = 2'b01;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_x = 1'b1;
        ctrl.alu_src_y = 2'b01;
        ctrl.add_sub   = 1'b1;
        ctrl.fn_class  = 2'b10;
        ctrl.br_cond   = 1'b1;
        ctrl.pc_src    = 2'b10;
        // The single Mealy term: branch resolution uses the live zero flag.
        ctrl.pc_write  = ((op_q == OP_BEQ) & bus.zero_in) | ((op_q == OP_BNE) & ~bus.zero_in);
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        if (op_q == OP_J || op_q == OP_JAL) begin
          ctrl.jump_addr = 1'b1;
          ctrl.pc_src    = 2'b01;
        end
        if (op_q == OP_JAL) begin
          ctrl.reg_dst    = 2'b10;
          ctrl.reg_in_src = 2'b10;
          ctrl.reg_write  = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_HALT: begin
        in_halt = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates the outputs combinationally so nothing is driven before the flops settle.
  assign bus.ctrl_out      = reset ? '0 : ctrl;
  assign bus.state_out     = state_q;
  assign bus.illegal_instr = illegal & ~reset;
  assign bus.halted        = in_halt & ~reset;

`ifdef MIPS_CTRL_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   cnt_q <= '0;
    else if (state_q == S_FETCH) cnt_q <= cnt_q + 32'd1;
  end

  assign bus.instr_count = cnt_q;
`else
  assign bus.instr_count = '0;
`endif

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Scoreboard bench for mips_ctrl_fsm: per-instruction expected cycle sequences from a mnemonic model.
// Also valid with MIPS_CTRL_PERF_CNT_EN defined (instr_count is then modelled).
module tb_mips_ctrl_fsm;

`ifdef MIPS_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int W = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_ctrl_fsm_if bus();
  mips_ctrl_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e, got_e;
  int n_cmp = 0;
  int n_err = 0;
  int fetch_cnt = 0;

  logic [3:0]  sq_st[6];
  logic [21:0] sq_c[6];
  logic        sq_ill[6];
  int          sq_n;

  // ---------------- reference model ----------------
  function automatic string mnem(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'd0: case (fn)
        6'd32: return "add";  6'd34: return "sub";  6'd42: return "slt";
        6'd36: return "and";  6'd37: return "or";   6'd38: return "xor";
        6'd39: return "nor";  6'd8:  return "jr";   6'd12: return "syscall";
        default: return "ill";
      endcase
      6'd35: return "lw";   6'd43: return "sw";   6'd8:  return "addi"; 6'd10: return "slti";
      6'd12: return "andi"; 6'd13: return "ori";  6'd14: return "xori"; 6'd15: return "lui";
      6'd4:  return "beq";  6'd5:  return "bne";  6'd2:  return "j";    6'd3:  return "jal";
      default: return "ill";
    endcase
  endfunction

  // {AddSub, LogicFn, FnClass} for an ALU mnemonic
  function automatic logic [4:0] alu_of(input string mn);
    if (mn == "add" || mn == "addi") return 5'b0_00_10;
    if (mn == "sub")                 return 5'b1_00_10;
    if (mn == "slt" || mn == "slti") return 5'b1_00_01;
    if (mn == "and" || mn == "andi") return 5'b0_00_11;
    if (mn == "or"  || mn == "ori")  return 5'b0_01_11;
    if (mn == "xor" || mn == "xori") return 5'b0_10_11;
    if (mn == "nor")                 return 5'b0_11_11;
    return 5'b0_00_00;
  endfunction

  function automatic logic [21:0] cw(input logic ja, input logic [1:0] pcs, input logic pcw,
      input logic idt, input logic mrd, input logic mwr, input logic irw, input logic [1:0] rdst,
      input logic [1:0] rin, input logic rw, input logic asx, input logic [1:0] asy,
      input logic [4:0] alu, input logic brc);
    return {ja, pcs, pcw, idt, mrd, mwr, irw, rdst, rin, rw, asx, asy, alu, brc};
  endfunction

  function automatic bit is_ralu(input string mn);
    return mn == "add" || mn == "sub" || mn == "slt" || mn == "and" || mn == "or" ||
           mn == "xor" || mn == "nor";
  endfunction

  function automatic bit is_imm(input string mn);
    return mn == "addi" || mn == "slti" || mn == "andi" || mn == "ori" || mn == "xori" ||
           mn == "lui";
  endfunction

  task automatic add_cyc(input logic [3:0] st, input logic [21:0] c);
    sq_st[sq_n] = st; sq_c[sq_n] = c; sq_ill[sq_n] = 1'b0; sq_n++;
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, output string mn);
    logic [4:0] add_f;
    add_f = alu_of("add");
    mn = mnem(op, fn);
    sq_n = 0;
    add_cyc(4'd0, cw(0, 2'b11, 1, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 2'b00, add_f, 0));
    add_cyc(4'd1, cw(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, add_f, 0));
    if (mn == "ill") sq_ill[1] = 1'b1;
    if (mn == "lw" || mn == "sw")
      add_cyc(4'd2, cw(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, add_f, 0));
    if (mn == "lw") begin
      add_cyc(4'd3, cw(0, 2'b00, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 5'b0, 0));
      add_cyc(4'd4, cw(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 5'b0, 0));
    end
    if (mn == "sw")
      add_cyc(4'd5, cw(0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 5'b0, 0));
    if (is_ralu(mn)) begin
      add_cyc(4'd6, cw(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b01, alu_of(mn), 0));
      add_cyc(4'd7, cw(0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b01, 1, 0, 2'b00, 5'b0, 0));
    end
    if (is_imm(mn)) begin
      add_cyc(4'd8, cw(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, alu_of(mn), 0));
      add_cyc(4'd9, cw(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 5'b0, 0));
    end
    if (mn == "beq" || mn == "bne")
      add_cyc(4'd10, cw(0, 2'b10, (mn == "beq") ? z : ~z, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b01,
                        alu_of("sub"), 1));
    if (mn == "j")
      add_cyc(4'd11, cw(1, 2'b01, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 5'b0, 0));
    if (mn == "jal")
      add_cyc(4'd11, cw(1, 2'b01, 1, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 5'b0, 0));
    if (mn == "jr")
      add_cyc(4'd11, cw(0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 5'b0, 0));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rv, input logic [5:0] ov, input logic [5:0] fv, input logic zv,
                      input logic [3:0] st, input logic [21:0] c, input logic il, input logic hl);
    @(posedge clk);
    #1;
    reset = rv;
    bus.op_in = ov;
    bus.fn_in = fv;
    bus.zero_in = zv;
    if (rv) fetch_cnt = 0;
    exp_q.push_back({st, c, il, hl, PERF ? 32'(fetch_cnt) : 32'd0});
    if (PERF && !rv && st == 4'd0) fetch_cnt++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
           4'd0, 22'd0, 1'b0, 1'b0);
  endtask

  // Runs one instruction (optionally only its first max_cyc cycles); syscall halts, then resets.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int max_cyc = 99);
    string mn;
    build(op, fn, z, mn);
    for (int i = 0; i < sq_n && i < max_cyc; i++) begin
      if (i < 2) step(1'b0, op, fn, z, sq_st[i], sq_c[i], sq_ill[i], 1'b0);
      else step(1'b0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), z,
                sq_st[i], sq_c[i], sq_ill[i], 1'b0);
    end
    if (mn == "syscall" && max_cyc >= 99) begin
      for (int i = 0; i < 4; i++)
        step(1'b0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
             4'd12, 22'd0, 1'b0, 1'b1);
      do_reset(2);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        got_e = {bus.state_out, bus.ctrl_out, bus.illegal_instr, bus.halted, bus.instr_count};
        n_cmp++;
        if (got_e !== exp_e) begin
          n_err++;
          $display("FAIL cycle_check t=%0t got st=%0d ctrl=%h ill=%b hlt=%b cnt=%0d required st=%0d ctrl=%h ill=%b hlt=%b cnt=%0d",
                   $time, got_e[59:56], got_e[55:34], got_e[33], got_e[32], got_e[31:0],
                   exp_e[59:56], exp_e[55:34], exp_e[33], exp_e[32], exp_e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int pool_op[23] = '{35, 43, 0, 0, 0, 0, 0, 0, 0, 8, 10, 12, 13, 14, 15, 4, 5, 2, 3, 0, 63, 0, 20};
  int pool_fn[23] = '{0, 0, 37, 32, 34, 42, 36, 38, 39, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 5};

  initial begin
    int k;
    int guard;
    bus.op_in = '0;
    bus.fn_in = '0;
    bus.zero_in = 1'b0;
    do_reset(2);

    // every pool entry once, branches with both zero flag values
    for (int i = 0; i < 23; i++) run_instr(6'(pool_op[i]), 6'(pool_fn[i]), 1'b0);
    run_instr(6'd4, 6'd0, 1'b1);
    run_instr(6'd5, 6'd0, 1'b1);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) == 0)
        run_instr(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      else begin
        k = $urandom_range(0, 22);
        run_instr(6'(pool_op[k]), 6'(pool_fn[k]), 1'($urandom_range(0, 1)));
      end
    end

    // reset asserted in MEMRD of a lw, then in BRANCH
    run_instr(6'd35, 6'd0, 1'b0, 3);
    do_reset(2);
    run_instr(6'd4, 6'd0, 1'b1, 2);
    do_reset(1);

    // three addi then syscall: count of 4 held through HALT
    do_reset(2);
    for (int i = 0; i < 3; i++) run_instr(6'd8, 6'($urandom_range(0, 63)), 1'b0);
    run_instr(6'd0, 6'd12, 1'b0);
    run_instr(6'd0, 6'd37, 1'b0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
